systolic_pe: RTL and testbench

Parametrised output-stationary processing element for the systolic matrix-multiply array; successor to the single-accumulator PE.
- Multiplies streaming A (flowing east) and B (flowing south) operands and accumulates them into a local result over a framed dot product (first/last beats).
- Forwards operands to neighbours with one-cycle registration.
- Hands each completed result into a per-row drain shift chain, so results leave the array while the next tile accumulates.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/pe_mul_stage.sv | 40 ++++
 rtl/systolic_pe.sv | 151 +++++++++++++++
 tb/tb_systolic_pe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and default widths for the systolic PE
package systolic_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ACC_W  = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_flags_t;

endpackage

// File: rtl/pe_mul_stage.sv
// rtl/pe_mul_stage.sv - unsigned multiplier with 0/1 register stages, beat flags carried alongside
module pe_mul_stage
    import systolic_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MUL_PIPE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  beat_flags_t         flags_in,
    output logic [2*DATA_W-1:0] product,
    output beat_flags_t         flags_out
);

    logic [2*DATA_W-1:0] prod_comb;

    assign prod_comb = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    generate
        if (MUL_PIPE == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign product   = prod_comb;
            assign flags_out = flags_in;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    product   <= '0;
                    flags_out <= '0;
                end else begin
                    product   <= prod_comb;
                    flags_out <= flags_in;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary systolic PE with framed accumulate and drain chain
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int MUL_PIPE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic              a_first_in,
    input  logic              a_last_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_valid_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic              a_first_out,
    output logic              a_last_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_valid_out,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_valid_in,
    input  logic              shift_en,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_valid_out,
    output logic [ACC_W-1:0]  acc_dbg,
    input  logic              err_clr,
    output logic              err,
    output logic              overrun
);

    beat_flags_t         in_flags;
    beat_flags_t         p_flags;
    logic [2*DATA_W-1:0] p_prod;
    logic [ACC_W-1:0]    prod_ext;

    pe_state_t           state;
    pe_state_t           next_state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    next_acc;
    logic                accept;
    logic                load_result;
    logic                seq_err;
    logic                ovr_set;
    logic                err_set;

    assign in_flags = {a_valid_in & b_valid_in, a_first_in, a_last_in};

    pe_mul_stage #(
        .DATA_W   (DATA_W),
        .MUL_PIPE (MUL_PIPE)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .a         (a_in),
        .b         (b_in),
        .flags_in  (in_flags),
        .product   (p_prod),
        .flags_out (p_flags)
    );

    assign prod_ext = ACC_W'(p_prod);
    assign acc_dbg  = acc;

    // A first beat always restarts the tile, even mid-accumulation.
    always_comb begin
        next_state  = state;
        next_acc    = acc;
        accept      = 1'b0;
        load_result = 1'b0;
        seq_err     = 1'b0;
        if (p_flags.valid) begin
            if (p_flags.first) begin
                next_acc = prod_ext;
                accept   = 1'b1;
            end else if (state == ACCUM) begin
                next_acc = acc + prod_ext;
                accept   = 1'b1;
            end else begin
                seq_err = 1'b1;
            end
            if (accept) begin
                if (p_flags.last) begin
                    next_state  = IDLE;
                    load_result = 1'b1;
                end else begin
                    next_state = ACCUM;
                end
            end
        end
    end

    assign ovr_set = load_result &
                     ((drain_valid_out & ~shift_en) | (shift_en & drain_valid_in));
    assign err_set = (a_valid_in ^ b_valid_in) | seq_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= next_state;
            acc   <= next_acc;
        end
    end

    // Result load outranks the row shift; a colliding shift loses its data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_out       <= '0;
            drain_valid_out <= 1'b0;
        end else if (load_result) begin
            drain_out       <= next_acc;
            drain_valid_out <= 1'b1;
        end else if (shift_en) begin
            drain_out       <= drain_in;
            drain_valid_out <= drain_valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            err     <= err_set | (err & ~err_clr);
            overrun <= ovr_set | (overrun & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out       <= '0;
            a_valid_out <= 1'b0;
            a_first_out <= 1'b0;
            a_last_out  <= 1'b0;
            b_out       <= '0;
            b_valid_out <= 1'b0;
        end else begin
            a_out       <= a_in;
            a_valid_out <= a_valid_in;
            a_first_out <= a_first_in;
            a_last_out  <= a_last_in;
            b_out       <= b_in;
            b_valid_out <= b_valid_in;
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - scoreboard bench driving MUL_PIPE=0 and MUL_PIPE=1 PEs in lockstep
module tb_systolic_pe;

    localparam int K_DRAIN  = 0;
    localparam int K_DVALID = 1;
    localparam int K_ACC    = 2;
    localparam int K_ERR    = 3;
    localparam int K_OVR    = 4;
    localparam int K_AOUT   = 5;
    localparam int K_BOUT   = 6;
    localparam int K_AFLAGS = 7;
    localparam int K_BVALID = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_in, b_in;
    logic        a_valid_in, a_first_in, a_last_in, b_valid_in;
    logic [63:0] drain_in;
    logic        drain_valid_in, shift_en, err_clr;

    logic [31:0] a_out_x [2];
    logic [31:0] b_out_x [2];
    logic        av_x [2];
    logic        af_x [2];
    logic        al_x [2];
    logic        bv_x [2];
    logic [63:0] dr_x [2];
    logic        dv_x [2];
    logic [63:0] acc_x [2];
    logic        err_x [2];
    logic        ovr_x [2];

    always #5 clk = ~clk;

    systolic_pe #(.DATA_W(32), .ACC_W(64), .MUL_PIPE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in), .a_last_in(a_last_in),
        .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out_x[1]), .a_valid_out(av_x[1]), .a_first_out(af_x[1]), .a_last_out(al_x[1]),
        .b_out(b_out_x[1]), .b_valid_out(bv_x[1]),
        .drain_in(drain_in), .drain_valid_in(drain_valid_in), .shift_en(shift_en),
        .drain_out(dr_x[1]), .drain_valid_out(dv_x[1]), .acc_dbg(acc_x[1]),
        .err_clr(err_clr), .err(err_x[1]), .overrun(ovr_x[1])
    );

    systolic_pe #(.DATA_W(32), .ACC_W(64), .MUL_PIPE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .a_first_in(a_first_in), .a_last_in(a_last_in),
        .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out_x[0]), .a_valid_out(av_x[0]), .a_first_out(af_x[0]), .a_last_out(al_x[0]),
        .b_out(b_out_x[0]), .b_valid_out(bv_x[0]),
        .drain_in(drain_in), .drain_valid_in(drain_valid_in), .shift_en(shift_en),
        .drain_out(dr_x[0]), .drain_valid_out(dv_x[0]), .acc_dbg(acc_x[0]),
        .err_clr(err_clr), .err(err_x[0]), .overrun(ovr_x[0])
    );

    typedef struct {
        int          d;
        int          due;
        int          kind;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] last_result = '0;
    logic [31:0] ta [8];
    logic [31:0] tb [8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] get(input int d, input int k);
        case (k)
            K_DRAIN:  return dr_x[d];
            K_DVALID: return {63'd0, dv_x[d]};
            K_ACC:    return acc_x[d];
            K_ERR:    return {63'd0, err_x[d]};
            K_OVR:    return {63'd0, ovr_x[d]};
            K_AOUT:   return {32'd0, a_out_x[d]};
            K_BOUT:   return {32'd0, b_out_x[d]};
            K_AFLAGS: return {61'd0, av_x[d], af_x[d], al_x[d]};
            K_BVALID: return {63'd0, bv_x[d]};
            default:  return '1;
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_DRAIN:  return "drain_out";
            K_DVALID: return "drain_valid_out";
            K_ACC:    return "acc_dbg";
            K_ERR:    return "err";
            K_OVR:    return "overrun";
            K_AOUT:   return "a_out";
            K_BOUT:   return "b_out";
            K_AFLAGS: return "a_flags_out";
            K_BVALID: return "b_valid_out";
            default:  return "unknown";
        endcase
    endfunction

    // Monitor: compares every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                n_checks++;
                if (sb[i].due == cyc && get(sb[i].d, sb[i].kind) === sb[i].val)
                    n_pass++;
                else
                    $display("FAIL %s pipe%0d cyc=%0d due=%0d actual=0x%0h required=0x%0h",
                             kname(sb[i].kind), sb[i].d, cyc, sb[i].due,
                             get(sb[i].d, sb[i].kind), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic expect_v(input int d, input int due, input int kind, input logic [63:0] v);
        exp_t e;
        e.d = d; e.due = due; e.kind = kind; e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        a_valid_in = 1'b0; b_valid_in = 1'b0;
        a_first_in = 1'b0; a_last_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) tick();
    endtask

    task automatic check_all_zero();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k <= K_BVALID; k++)
                expect_v(d, cyc, k, 64'd0);
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, cyc, K_ERR, 64'd0);
            expect_v(d, cyc, K_OVR, 64'd0);
        end
    endtask

    // Reference: a tile's result is the wrapped sum of its products.
    task automatic run_tile(input int n);
        logic [63:0] sum;
        sum = '0;
        for (int i = 0; i < n; i++)
            sum = sum + 64'(ta[i]) * 64'(tb[i]);
        for (int i = 0; i < n; i++) begin
            a_in = ta[i]; b_in = tb[i];
            a_valid_in = 1'b1; b_valid_in = 1'b1;
            a_first_in = (i == 0);
            a_last_in  = (i == n - 1);
            if (i == n - 1)
                for (int d = 0; d < 2; d++) begin
                    expect_v(d, cyc + 1 + d, K_DRAIN, sum);
                    expect_v(d, cyc + 1 + d, K_DVALID, 64'd1);
                    expect_v(d, cyc + 1 + d, K_ACC, sum);
                end
            tick();
        end
        quiet();
        last_result = sum;
    endtask

    initial begin
        logic [63:0] r;
        rst = 1'b0;
        a_in = '0; b_in = '0; drain_in = '0;
        drain_valid_in = 1'b0; shift_en = 1'b0; err_clr = 1'b0;
        quiet();
        repeat (2) tick();
        check_all_zero();
        tick();
        rst = 1'b1;
        tick();

        // dot product 2*3 + 4*5 + 6*7 = 68
        ta[0] = 2; tb[0] = 3; ta[1] = 4; tb[1] = 5; ta[2] = 6; tb[2] = 7;
        run_tile(3);
        for (int d = 0; d < 2; d++) expect_v(d, cyc + d, K_ERR, 64'd0);
        idle(4);

        // wraparound
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
        run_tile(2);
        idle(4);
        clear_flags();

        // one-sided beats: forwarding only, error raised
        for (int i = 0; i < 4; i++) begin
            a_in = $urandom; b_in = $urandom;
            a_valid_in = (i % 2 == 0); b_valid_in = (i % 2 == 1);
            a_first_in = 1'($urandom_range(0, 1));
            a_last_in  = 1'($urandom_range(0, 1));
            for (int d = 0; d < 2; d++) begin
                expect_v(d, cyc + 1, K_AOUT, {32'd0, a_in});
                expect_v(d, cyc + 1, K_BOUT, {32'd0, b_in});
                expect_v(d, cyc + 1, K_AFLAGS, {61'd0, a_valid_in, a_first_in, a_last_in});
                expect_v(d, cyc + 1, K_BVALID, {63'd0, b_valid_in});
                expect_v(d, cyc + 1, K_ERR, 64'd1);
                expect_v(d, cyc + 1 + d, K_ACC, last_result);
            end
            tick();
        end
        idle(2);
        clear_flags();

        // beat without first while idle is ignored and flagged
        a_in = 3; b_in = 3; a_valid_in = 1'b1; b_valid_in = 1'b1;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, cyc + 1 + d, K_ERR, 64'd1);
            expect_v(d, cyc + 2, K_ACC, last_result);
        end
        tick();
        idle(3);
        clear_flags();

        // result collides with an incoming drain shift
        r = 64'($urandom_range(1, 65535)) * 64'($urandom_range(1, 65535));
        a_in = 32'(r >> 32); b_in = 32'(r);
        r = 64'(a_in) * 64'(b_in);
        a_valid_in = 1'b1; b_valid_in = 1'b1; a_first_in = 1'b1; a_last_in = 1'b1;
        shift_en = 1'b1; drain_valid_in = 1'b1; drain_in = 64'h55;
        for (int d = 0; d < 2; d++) begin
            expect_v(d, cyc + 1 + d, K_DRAIN, r);
            expect_v(d, cyc + 1 + d, K_OVR, 64'd1);
        end
        tick();
        quiet();
        tick();
        shift_en = 1'b0; drain_valid_in = 1'b0;
        last_result = r;
        idle(2);

        // result overwrites an unshifted valid result
        clear_flags();
        ta[0] = $urandom; tb[0] = $urandom;
        for (int d = 0; d < 2; d++) expect_v(d, cyc + 1 + d, K_OVR, 64'd1);
        run_tile(1);
        idle(3);

        // reset in the middle of a tile
        a_in = 2; b_in = 3; a_valid_in = 1'b1; b_valid_in = 1'b1; a_first_in = 1'b1;
        tick();
        a_in = 4; b_in = 5; a_first_in = 1'b0;
        tick();
        quiet();
        rst = 1'b0;
        check_all_zero();
        tick();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) expect_v(d, cyc + 2, K_DVALID, 64'd0);
        idle(3);
        ta[0] = 9; tb[0] = 9;
        run_tile(1);
        idle(3);

        // back-to-back tiles, no bubble
        ta[0] = 2; tb[0] = 3; ta[1] = 4; tb[1] = 5; ta[2] = 6; tb[2] = 7;
        run_tile(3);
        ta[0] = 9; tb[0] = 9;
        run_tile(1);
        idle(4);

        // random back-to-back tiles
        repeat (6) begin
            int n;
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                ta[i] = $urandom; tb[i] = $urandom;
            end
            run_tile(n);
        end
        idle(4);

        // plain drain shifting
        for (int i = 0; i < 3; i++) begin
            shift_en = 1'b1;
            drain_in = {$urandom, $urandom};
            drain_valid_in = (i != 2);
            for (int d = 0; d < 2; d++) begin
                expect_v(d, cyc + 1, K_DRAIN, drain_in);
                expect_v(d, cyc + 1, K_DVALID, {63'd0, drain_valid_in});
            end
            tick();
        end
        shift_en = 1'b0; drain_valid_in = 1'b0;

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
